// File: rtl/dispatch_pkg.sv
// Shared constants and types for the in-order dispatch/rename stage:
// internal opcodes, MIPS encodings and the register-status-table entry.
package dispatch_pkg;

  localparam logic [3:0] IOP_ADD  = 4'd0;
  localparam logic [3:0] IOP_SUB  = 4'd1;
  localparam logic [3:0] IOP_AND  = 4'd2;
  localparam logic [3:0] IOP_OR   = 4'd3;
  localparam logic [3:0] IOP_SLT  = 4'd4;
  localparam logic [3:0] IOP_SLL  = 4'd5;
  localparam logic [3:0] IOP_SRL  = 4'd6;
  localparam logic [3:0] IOP_ADDI = 4'd7;
  localparam logic [3:0] IOP_LW   = 4'd8;
  localparam logic [3:0] IOP_SW   = 4'd9;
  localparam logic [3:0] IOP_MUL  = 4'd10;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;

  // Tag field sized for the widest supported TAG_W; the top uses the low TAG_W bits.
  localparam int RST_TAG_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [RST_TAG_W-1:0] tag;
  } rst_entry_t;

  typedef enum logic [1:0] {Q_NONE, Q_INT, Q_LDST, Q_MUL} queue_sel_t;

endpackage

// File: rtl/dispatch_rename_unit_tag_free_list.sv
// Circular FIFO of free rename tags; resets full with tags 0..2**TAG_W-1 in pop order.
module tag_free_list #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pop,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  output logic [TAG_W-1:0] pop_tag,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 2**TAG_W;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (TAG_W+1)'(DEPTH));
  // Both qualifiers use the registered count, so a same-cycle push never feeds an empty pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign pop_tag = mem[head];

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= (TAG_W+1)'(DEPTH);
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(i);
    end else begin
      if (do_push) begin
        mem[tail] <= push_tag;
        tail      <= tail + 1'b1;
      end
      if (do_pop) head <= head + 1'b1;
      count <= count + (TAG_W+1)'(do_push) - (TAG_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/dispatch_rename_unit.sv
// In-order single-issue dispatch: decode, rename via RST + free list, operand
// resolution with same-cycle CDB forwarding, and jump redirect.
module dispatch_rename_unit
  import dispatch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       ifetch_pc_4,
  input  logic [31:0]       ifetch_intruction,
  input  logic              ifetch_empty,
  output logic              Dispatch_ren,
  output logic              Dispatch_jmp,
  output logic [31:0]       Dispatch_jmp_addr,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] dispatch_rs_data,
  output logic [DATA_W-1:0] dispatch_rt_data,
  output logic              dispatch_rs_data_valid,
  output logic              dispatch_rt_data_valid,
  output logic [TAG_W-1:0]  dispatch_rs_tag,
  output logic [TAG_W-1:0]  dispatch_rt_tag,
  output logic [TAG_W-1:0]  dispatch_rd_tag,
  output logic [3:0]        dispatch_opcode,
  output logic [4:0]        dispatch_shfamt,
  output logic [15:0]       dispatch_imm,
  output logic              dispatch_en_integer,
  output logic              dispatch_en_ld_st,
  output logic              dispatch_en_mul,
  input  logic              issueque_integer_full,
  input  logic              issueque_full_ld_st,
  input  logic              issueque_mul_full
);
  localparam int NREG = 32;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } src_t;

  rst_entry_t        rst [NREG];
  logic [DATA_W-1:0] rf  [NREG];

  logic [5:0] opc, funct;
  logic [4:0] rs_f, rt_f, rd_f, dest;
  logic [3:0] iop;
  queue_sel_t qsel;
  logic       has_dest, rs_used, rt_used, is_jmp, is_nop, q_full;
  logic       fire, consume, fl_pop, fl_empty, fl_full;
  logic [TAG_W-1:0] fl_tag;
  src_t       rs_src, rt_src;
  logic       unused_ok;

  assign opc   = ifetch_intruction[31:26];
  assign rs_f  = ifetch_intruction[25:21];
  assign rt_f  = ifetch_intruction[20:16];
  assign rd_f  = ifetch_intruction[15:11];
  assign funct = ifetch_intruction[5:0];

  always_comb begin
    iop      = IOP_ADD;
    qsel     = Q_NONE;
    has_dest = 1'b0;
    dest     = '0;
    rs_used  = 1'b1;
    rt_used  = 1'b1;
    is_jmp   = 1'b0;
    case (opc)
      OPC_RTYPE: begin
        qsel     = Q_INT;
        has_dest = 1'b1;
        dest     = rd_f;
        case (funct)
          FN_ADD:  iop = IOP_ADD;
          FN_SUB:  iop = IOP_SUB;
          FN_AND:  iop = IOP_AND;
          FN_OR:   iop = IOP_OR;
          FN_SLT:  iop = IOP_SLT;
          FN_SLL:  begin iop = IOP_SLL; rs_used = 1'b0; end
          FN_SRL:  begin iop = IOP_SRL; rs_used = 1'b0; end
          FN_MULT, FN_MULTU: begin iop = IOP_MUL; qsel = Q_MUL; end
          default: begin qsel = Q_NONE; has_dest = 1'b0; end
        endcase
      end
      OPC_ADDI: begin
        iop = IOP_ADDI; qsel = Q_INT; has_dest = 1'b1; dest = rt_f; rt_used = 1'b0;
      end
      OPC_LW: begin
        iop = IOP_LW; qsel = Q_LDST; has_dest = 1'b1; dest = rt_f; rt_used = 1'b0;
      end
      OPC_SW:  begin iop = IOP_SW; qsel = Q_LDST; end
      OPC_J:   is_jmp = 1'b1;
      default: ;
    endcase
  end

  function automatic src_t resolve(input logic [4:0] r, input logic used);
    src_t s;
    s.valid = 1'b1;
    s.tag   = '0;
    s.data  = '0;
    if (used && r != 5'd0) begin
      if (!rst[r].valid)
        s.data = rf[r];
      else if (cdb_valid && rst[r].tag == RST_TAG_W'(cdb_tag))
        s.data = cdb_data;
      else begin
        s.valid = 1'b0;
        s.tag   = rst[r].tag[TAG_W-1:0];
      end
    end
    return s;
  endfunction

  always_comb begin
    rs_src = resolve(rs_f, rs_used);
    rt_src = resolve(rt_f, rt_used);
  end

  always_comb begin
    case (qsel)
      Q_INT:   q_full = issueque_integer_full;
      Q_LDST:  q_full = issueque_full_ld_st;
      Q_MUL:   q_full = issueque_mul_full;
      default: q_full = 1'b0;
    endcase
  end

  // Writes to $0 are dropped without a tag; jumps and unsupported words just drain.
  assign is_nop  = has_dest && (dest == 5'd0);
  assign fire    = !reset && !ifetch_empty && (qsel != Q_NONE) && !is_nop && !q_full &&
                   (!has_dest || !fl_empty);
  assign consume = !reset && !ifetch_empty && ((qsel == Q_NONE) || is_nop);
  assign fl_pop  = fire && has_dest;

  assign Dispatch_ren        = fire || consume;
  assign Dispatch_jmp        = consume && is_jmp;
  assign Dispatch_jmp_addr   = {ifetch_pc_4[31:28], ifetch_intruction[25:0], 2'b00};
  assign dispatch_en_integer = fire && (qsel == Q_INT);
  assign dispatch_en_ld_st   = fire && (qsel == Q_LDST);
  assign dispatch_en_mul     = fire && (qsel == Q_MUL);

  assign dispatch_rs_data       = rs_src.data;
  assign dispatch_rs_data_valid = rs_src.valid;
  assign dispatch_rs_tag        = rs_src.tag;
  assign dispatch_rt_data       = rt_src.data;
  assign dispatch_rt_data_valid = rt_src.valid;
  assign dispatch_rt_tag        = rt_src.tag;
  assign dispatch_rd_tag        = fl_tag;
  assign dispatch_opcode        = iop;
  assign dispatch_shfamt        = ifetch_intruction[10:6];
  assign dispatch_imm           = ifetch_intruction[15:0];

  assign unused_ok = ^{ifetch_pc_4[27:0], fl_full};

  tag_free_list #(.TAG_W(TAG_W)) u_free_list (
    .clock    (clock),
    .reset    (reset),
    .pop      (fl_pop),
    .push     (cdb_valid),
    .push_tag (cdb_tag),
    .pop_tag  (fl_tag),
    .empty    (fl_empty),
    .full     (fl_full)
  );

  // CDB writeback first; a rename of the same register in this cycle overrides the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        rst[r] <= '0;
        rf[r]  <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (cdb_valid && rst[r].valid && rst[r].tag == RST_TAG_W'(cdb_tag)) begin
          rf[r]        <= cdb_data;
          rst[r].valid <= 1'b0;
        end
      end
      if (fl_pop) rst[dest] <= '{valid: 1'b1, tag: RST_TAG_W'(fl_tag)};
    end
  end

endmodule
